// File: rtl/edge_det_pkg.sv
// edge_det_pkg: shared mode encoding and idle line level for the edge detector
package edge_det_pkg;
  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int FC_W = 4;
endpackage

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel of synchronizer, glitch filter, qualified pulse, sticky flag and saturating count
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             din,
  input  mode_e            mode,
  input  logic             clr,
  output logic             pulse,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic f_q, f_d, pulse_q, pulse_d, flag_q, flag_d;
  logic s, commit, hit;
  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, din});
    s = sync_q[SYNC_STAGES-1];
    commit = (s != f_q) && (fc_q == FC_W'(FILTER_LEN - 1));
    f_d = commit ? s : f_q;
    fc_d = (s == f_q || commit) ? '0 : fc_q + FC_W'(1);
    hit = commit && (s ? (mode == MODE_RISE || mode == MODE_BOTH)
                       : (mode == MODE_FALL || mode == MODE_BOTH));
    pulse_d = hit;
    flag_d = hit | (flag_q & ~clr);
    cnt_d = clr ? CNT_W'(hit) : cnt_q + CNT_W'(hit && cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      f_q     <= IDLE_LEVEL;
      fc_q    <= '0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      f_q     <= f_d;
      fc_q    <= fc_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pulse = pulse_q;
  assign flag  = flag_q;
  assign cnt   = cnt_q;
endmodule

// File: rtl/multi_edge_det.sv
// multi_edge_det: NUM_CH independent filtered edge detectors sharing a global mode qualifier
module multi_edge_det
  import edge_det_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_CH-1:0]       serial_in,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       clear_flags,
  output logic [NUM_CH-1:0]       edge_detected,
  output logic [NUM_CH-1:0]       edge_flags,
  output logic [NUM_CH*CNT_W-1:0] edge_count
);
  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_det_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .CNT_W      (CNT_W)
      ) u_chan (
        .clk  (clk),
        .n_rst(n_rst),
        .din  (serial_in[i]),
        .mode (mode_sel),
        .clr  (clear_flags[i]),
        .pulse(edge_detected[i]),
        .flag (edge_flags[i]),
        .cnt  (edge_count[i*CNT_W +: CNT_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_multi_edge_det.sv
// tb_multi_edge_det: vector table plus corner sequences, pulses checked against an expected-event queue
module tb_multi_edge_det;
  typedef struct {int cyc; logic [3:0] mask;} exp_t;
  typedef struct {int ch; logic lvl; logic [1:0] md; logic pulse; logic flag; int cnt;} vec_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] serial_in = 4'hf;
  logic [3:0] clear_flags = 4'h0;
  logic [1:0] mode = 2'b11;
  logic [3:0] edge_detected, edge_flags, ed_s, fl_s;
  logic [31:0] edge_count;
  logic [7:0] ec_s;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  multi_edge_det dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .mode(mode), .clear_flags(clear_flags),
    .edge_detected(edge_detected), .edge_flags(edge_flags), .edge_count(edge_count)
  );

  multi_edge_det #(.CNT_W(2)) dut_sat (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .mode(mode), .clear_flags(clear_flags),
    .edge_detected(ed_s), .edge_flags(fl_s), .edge_count(ec_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic int cnt_of(input int ch);
    return int'(edge_count[ch*8 +: 8]);
  endfunction

  task automatic expect_pulse(input logic [3:0] mask);
    exp_t e;
    e.cyc = cyc + 5;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_pulse_mask", 0, int'(e.mask));
    end
    if (edge_detected != 4'h0) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", int'(edge_detected), 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_mask", int'(edge_detected), int'(e.mask));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    vecs[0] = '{0, 1'b0, 2'b11, 1'b1, 1'b1, 1};
    vecs[1] = '{0, 1'b1, 2'b11, 1'b1, 1'b1, 2};
    vecs[2] = '{2, 1'b0, 2'b01, 1'b0, 1'b0, 0};
    vecs[3] = '{2, 1'b1, 2'b01, 1'b1, 1'b1, 1};
    vecs[4] = '{2, 1'b0, 2'b10, 1'b1, 1'b1, 2};
    vecs[5] = '{2, 1'b1, 2'b10, 1'b0, 1'b1, 2};
    vecs[6] = '{1, 1'b0, 2'b00, 1'b0, 1'b0, 0};
    vecs[7] = '{1, 1'b1, 2'b00, 1'b0, 1'b0, 0};
    repeat (3) @(negedge clk);
    chk("rst_detected", int'(edge_detected), 0);
    chk("rst_flags", int'(edge_flags), 0);
    chk("rst_count", int'(edge_count), 0);
    n_rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mode = vecs[k].md;
      serial_in[vecs[k].ch] = vecs[k].lvl;
      if (vecs[k].pulse) expect_pulse(4'(1 << vecs[k].ch));
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_flag", k), int'(edge_flags[vecs[k].ch]), int'(vecs[k].flag));
      chk($sformatf("vec%0d_count", k), cnt_of(vecs[k].ch), vecs[k].cnt);
    end
    @(negedge clk);
    mode = 2'b11;
    serial_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    serial_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch_flag1", int'(edge_flags[1]), 0);
    chk("glitch_count1", cnt_of(1), 0);
    @(negedge clk);
    serial_in[1:0] = 2'b00;
    expect_pulse(4'b0011);
    repeat (6) @(negedge clk);
    chk("simul_fall_count0", cnt_of(0), 3);
    chk("simul_fall_count1", cnt_of(1), 1);
    serial_in[1:0] = 2'b11;
    expect_pulse(4'b0011);
    repeat (6) @(negedge clk);
    chk("simul_rise_count0", cnt_of(0), 4);
    chk("simul_rise_count1", cnt_of(1), 2);
    chk("simul_flag1", int'(edge_flags[1]), 1);
    for (int k = 0; k < 5; k++) begin
      serial_in[3] = (k % 2 == 1);
      expect_pulse(4'b1000);
      repeat (6) @(negedge clk);
    end
    chk("sat_count3", int'(ec_s[7:6]), 3);
    chk("sat_flag3", int'(fl_s[3]), 1);
    chk("wide_count3", cnt_of(3), 5);
    serial_in[3] = 1'b1;
    expect_pulse(4'b1000);
    repeat (4) @(negedge clk);
    clear_flags[3] = 1'b1;
    @(negedge clk);
    clear_flags[3] = 1'b0;
    chk("clr_collide_flag3", int'(edge_flags[3]), 1);
    chk("clr_collide_count3", cnt_of(3), 1);
    chk("clr_collide_sat_count3", int'(ec_s[7:6]), 1);
    clear_flags[3] = 1'b1;
    @(negedge clk);
    clear_flags[3] = 1'b0;
    chk("clr_flag3", int'(edge_flags[3]), 0);
    chk("clr_count3", cnt_of(3), 0);
    chk("hold_flag0", int'(edge_flags[0]), 1);
    serial_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midfilter_fc", int'(dut.g_ch[0].u_chan.fc_q), 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_detected", int'(edge_detected), 0);
    chk("midrst_flags", int'(edge_flags), 0);
    chk("midrst_count", int'(edge_count), 0);
    chk("midrst_f", int'(dut.g_ch[0].u_chan.f_q), 1);
    chk("midrst_fc", int'(dut.g_ch[0].u_chan.fc_q), 0);
    chk("midrst_sync", int'(dut.g_ch[0].u_chan.sync_q), 3);
    n_rst = 1'b1;
    expect_pulse(4'b0001);
    repeat (6) @(negedge clk);
    chk("postrst_flag0", int'(edge_flags[0]), 1);
    chk("postrst_count0", cnt_of(0), 1);
    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multi_edge_det.md
MULTI_EDGE_DET -- requirements
Module: multi_edge_det

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent serial channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel, legal range 1..4.
REQ-003 Parameter FILTER_LEN, default 3: consecutive stable cycles required to accept a level change, legal range 1..15; a value of 1 means no filtering.
REQ-004 Parameter CNT_W, default 8: width of each per-channel edge counter.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port serial_in, input, NUM_CH bits: asynchronous serial lines; idle level is 1.
REQ-008 Port mode, input, 2 bits: global edge qualifier; 00 = none, 01 = rising, 10 = falling, 11 = both.
REQ-009 Port clear_flags, input, NUM_CH bits: per-channel write-1 clear for the sticky flag and the counter.
REQ-010 Port edge_detected, output, NUM_CH bits: one-cycle pulse per qualified edge.
REQ-011 Port edge_flags, output, NUM_CH bits: sticky per-channel edge-seen flag.
REQ-012 Port edge_count, output, NUM_CH*CNT_W bits: per-channel edge counts; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-013 Each channel SHALL pass serial_in[i] through SYNC_STAGES flops; the output of the last flop is signal s.
REQ-014 Each channel SHALL hold a filtered level f and a filter counter fc with range 0..FILTER_LEN-1.
REQ-015 The filter SHALL update on every clock edge as follows:
 - s == f: fc SHALL be set to 0.
 - s != f and fc < FILTER_LEN-1: fc SHALL increment.
 - s != f and fc == FILTER_LEN-1: f SHALL be set to s, fc SHALL be set to 0, and a commit occurs.
REQ-016 A commit with f going from 0 to 1 SHALL be a rising edge; a commit with f going from 1 to 0 SHALL be a falling edge.
REQ-017 f SHALL track s whatever the value of mode; mode SHALL only gate reporting.
REQ-018 edge_detected[i] SHALL be a registered output, asserted for exactly one cycle on the commit edge when mode, sampled at that same edge, qualifies the edge direction.
REQ-019 Latency: a level change present at serial_in before rising edge 1 SHALL produce edge_detected high after rising edge SYNC_STAGES+FILTER_LEN; with default parameters this is edge 5.
REQ-020 A glitch shorter than FILTER_LEN synchronized cycles SHALL reset fc, produce no commit and produce no pulse.
REQ-021 A qualified pulse SHALL set edge_flags[i]; the flag SHALL hold until clear_flags[i] is 1 at a clock edge.
REQ-022 If a pulse and clear_flags[i] occur at the same edge, the set SHALL win and edge_flags[i] SHALL remain 1.
REQ-023 A qualified pulse SHALL increment edge_count for channel i, saturating at 2^CNT_W-1 with no wrap.
REQ-024 clear_flags[i] SHALL zero the count; if a pulse occurs at the same edge, the count SHALL become 1.
REQ-025 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported.
REQ-026 mode 00 SHALL suppress all pulses, flag sets and count increments.

Reset
REQ-027 When n_rst is 0 at a rising clk edge, the following SHALL be loaded:
 - every synchronizer flop and every f: 1 (idle);
 - every fc: 0;
 - edge_detected, edge_flags and edge_count: all 0.
REQ-028 With n_rst 0, no pulse SHALL be generated, regardless of serial_in.
REQ-029 After n_rst is released, a line held at 0 during reset SHALL commit as a falling edge after the normal latency.
REQ-030 Reset mid-filter SHALL discard the partial count.

Structure
REQ-031 A shared package edge_det_pkg SHALL hold:
 - the mode enum typedef (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH);
 - the IDLE_LEVEL constant = 1.
REQ-032 Per-channel logic SHALL reside in sub-module edge_det_chan.
REQ-033 multi_edge_det SHALL instantiate NUM_CH instances of edge_det_chan via generate.
REQ-034 The design SHALL contain no latches and no combinational path from serial_in to any output.

Verification
REQ-035 The bench SHALL use defaults and mode=11, driving ch0 from 1 to 0 at negedge; edge_detected[0] SHALL be high for exactly the cycle after posedge 5, edge_flags[0] SHALL be 1, and ch0 count SHALL be 1.
REQ-036 The bench SHALL apply a 2-cycle low glitch on ch1 with mode=11; there SHALL be no pulse, and edge_flags[1] and the ch1 count SHALL remain 0.
REQ-037 With mode=01, a ch2 fall followed by a ch2 rise SHALL give exactly one pulse, on the rise.
REQ-038 With mode=10, the same ch2 sequence SHALL give exactly one pulse, on the fall.
REQ-039 With CNT_W=2, 5 qualified edges on ch3 SHALL give count 3 (saturated).
REQ-040 clear_flags[3] asserted at the same edge as a ch3 pulse SHALL give edge_flags[3]=1 and ch3 count=1.
REQ-041 n_rst asserted while ch0 sits at fc=1 SHALL give all outputs 0 at the next edge, f=1 and fc=0; after release, ch0 held at 0 SHALL produce a falling pulse 5 cycles later.
